// File: rtl/arith_sched_pkg.sv
// Shared definitions for the two-domain arithmetic scheduler: opcodes, FSM states, domain ids.
// The optional scrub state is only entered when VC_ARITH_SCRUB_EN is defined.
package arith_sched_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_SLL = 3'd2;
    localparam logic [2:0] OP_SRL = 3'd3;
    localparam logic [2:0] OP_EQ  = 3'd4;
    localparam logic [2:0] OP_GT  = 3'd5;
    localparam logic [2:0] OP_GEQ = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_RESP  = 2'd2,
        ST_SCRUB = 2'd3
    } state_t;

    localparam logic DOMAIN_NS = 1'b0;
    localparam logic DOMAIN_S  = 1'b1;

endpackage

// File: rtl/arith_sched_alu.sv
// Combinational opcode decode and datapath for the shared arithmetic unit.
// Adder, subtractor, shifter and comparator are computed in parallel and muxed by opcode.
module arith_sched_alu
    import arith_sched_pkg::*;
#(
    parameter int p_nbits       = 32,
    parameter int p_shamt_nbits = 5
) (
    input  logic [2:0]         op,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic [p_nbits-1:0] result
);

    logic [p_nbits-1:0]       sum;
    logic [p_nbits-1:0]       diff;
    logic [p_nbits-1:0]       sll;
    logic [p_nbits-1:0]       srl;
    logic [p_shamt_nbits-1:0] shamt;
    logic                     eq;
    logic                     gt;

    assign shamt = in1[p_shamt_nbits-1:0];
    assign sum   = in0 + in1;
    assign diff  = in0 - in1;
    assign sll   = in0 << shamt;
    assign srl   = in0 >> shamt;
    assign eq    = (in0 == in1);
    assign gt    = (in0 > in1);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
            OP_SLL:  result = sll;
            OP_SRL:  result = srl;
            OP_EQ:   result = {{(p_nbits-1){1'b0}}, eq};
            OP_GT:   result = {{(p_nbits-1){1'b0}}, gt};
            OP_GEQ:  result = {{(p_nbits-1){1'b0}}, gt | eq};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/arith_unit_sched.sv
// Round-robin scheduler sharing one arithmetic unit between the non-secure (0) and secure (1) domains.
// VC_ARITH_SCRUB_EN adds a SCRUB cycle after each response that clears operands and result.
module arith_unit_sched
    import arith_sched_pkg::*;
#(
    parameter int p_nbits       = 32,
    parameter int p_shamt_nbits = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_val,
    output logic               req0_rdy,
    input  logic [2:0]         req0_op,
    input  logic [p_nbits-1:0] req0_in0,
    input  logic [p_nbits-1:0] req0_in1,
    input  logic               req1_val,
    output logic               req1_rdy,
    input  logic [2:0]         req1_op,
    input  logic [p_nbits-1:0] req1_in0,
    input  logic [p_nbits-1:0] req1_in1,
    output logic               resp0_val,
    input  logic               resp0_rdy,
    output logic [p_nbits-1:0] resp0_data,
    output logic               resp1_val,
    input  logic               resp1_rdy,
    output logic [p_nbits-1:0] resp1_data,
    output logic               cur_domain,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    // Handshake: a transfer fires on a rising clk edge where val and rdy are both high.
    // Requesters hold val (and payload) until they see rdy; the response port holds val and data until rdy.

    state_t             state;
    logic               last_grant;
    logic [2:0]         op_reg;
    logic [p_nbits-1:0] in0_reg;
    logic [p_nbits-1:0] in1_reg;
    logic [p_nbits-1:0] result_reg;
    logic [p_nbits-1:0] alu_result;
    logic               idle;
    logic               resp_fire;

    assign idle = reset_n && (state == ST_IDLE);

    // Round-robin: a lone requester always wins; on contention the one not granted last wins.
    assign req0_rdy = idle && req0_val && (!req1_val || last_grant);
    assign req1_rdy = idle && req1_val && (!req0_val || !last_grant);

    assign resp0_val  = (state == ST_RESP) && (cur_domain == DOMAIN_NS);
    assign resp1_val  = (state == ST_RESP) && (cur_domain == DOMAIN_S);
    assign resp0_data = resp0_val ? result_reg : '0;
    assign resp1_data = resp1_val ? result_reg : '0;
    assign resp_fire  = (resp0_val && resp0_rdy) || (resp1_val && resp1_rdy);

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    arith_sched_alu #(
        .p_nbits       (p_nbits),
        .p_shamt_nbits (p_shamt_nbits)
    ) u_alu (
        .op     (op_reg),
        .in0    (in0_reg),
        .in1    (in1_reg),
        .result (alu_result)
    );

    // cur_domain doubles as the owner of the in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            cur_domain <= DOMAIN_NS;
            op_reg     <= '0;
            in0_reg    <= '0;
            in1_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req1_rdy) begin
                        op_reg     <= req1_op;
                        in0_reg    <= req1_in0;
                        in1_reg    <= req1_in1;
                        cur_domain <= DOMAIN_S;
                        last_grant <= 1'b1;
                        state      <= ST_EXEC;
                    end else if (req0_rdy) begin
                        op_reg     <= req0_op;
                        in0_reg    <= req0_in0;
                        in1_reg    <= req0_in1;
                        cur_domain <= DOMAIN_NS;
                        last_grant <= 1'b0;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_reg <= alu_result;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_fire) begin
                        cur_domain <= DOMAIN_NS;
`ifdef VC_ARITH_SCRUB_EN
                        op_reg     <= '0;
                        in0_reg    <= '0;
                        in1_reg    <= '0;
                        result_reg <= '0;
                        state      <= ST_SCRUB;
`else
                        state      <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_unit_sched.sv
// Self-checking bench for arith_unit_sched: scoreboard of expected results keyed by owning domain.
module tb_arith_unit_sched;

    localparam int W = 32;
`ifdef VC_ARITH_SCRUB_EN
    localparam time SPACING = 40;
`else
    localparam time SPACING = 30;
`endif

    logic         clk;
    logic         reset_n;
    logic         req0_val, req1_val;
    logic         req0_rdy, req1_rdy;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_in0, req0_in1, req1_in0, req1_in1;
    logic         resp0_val, resp1_val;
    logic         resp0_rdy, resp1_rdy;
    logic [W-1:0] resp0_data, resp1_data;
    logic         cur_domain;
    logic         busy;
    logic [1:0]   dbg_state;

    int checks;
    int failures;

    logic [W:0] exp_q[$];
    int         grant_q[$];
    time        fire_t[$];

    arith_unit_sched #(.p_nbits(W), .p_shamt_nbits(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_val   (req0_val),
        .req0_rdy   (req0_rdy),
        .req0_op    (req0_op),
        .req0_in0   (req0_in0),
        .req0_in1   (req0_in1),
        .req1_val   (req1_val),
        .req1_rdy   (req1_rdy),
        .req1_op    (req1_op),
        .req1_in0   (req1_in0),
        .req1_in1   (req1_in1),
        .resp0_val  (resp0_val),
        .resp0_rdy  (resp0_rdy),
        .resp0_data (resp0_data),
        .resp1_val  (resp1_val),
        .resp1_rdy  (resp1_rdy),
        .resp1_data (resp1_data),
        .cur_domain (cur_domain),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a << sh;
            3'd3:    return a >> sh;
            3'd4:    return (a == b) ? 1 : 0;
            3'd5:    return (a > b) ? 1 : 0;
            3'd6:    return (a >= b) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    // ---------------- scoreboard monitor (samples on negedge) ----------------
    always @(negedge clk) begin
        logic [W:0] e;
        if (req0_val && req0_rdy) begin
            exp_q.push_back({1'b0, model(req0_op, req0_in0, req0_in1)});
            grant_q.push_back(0);
            fire_t.push_back($time);
        end
        if (req1_val && req1_rdy) begin
            exp_q.push_back({1'b1, model(req1_op, req1_in0, req1_in1)});
            grant_q.push_back(1);
            fire_t.push_back($time);
        end
        if (resp0_val && resp0_rdy) begin
            if (exp_q.size() == 0) check("resp0_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("resp0_owner_data", {1'b0, resp0_data}, e);
            end
        end
        if (resp1_val && resp1_rdy) begin
            if (exp_q.size() == 0) check("resp1_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("resp1_owner_data", {1'b1, resp1_data}, e);
            end
        end
        if (!resp0_val) check("resp0_data_when_idle", resp0_data, 0);
        if (!resp1_val) check("resp1_data_when_idle", resp1_data, 0);
`ifdef VC_ARITH_SCRUB_EN
        if (dbg_state == 2'd3) check("scrub_result_reg", dut.result_reg, 0);
`endif
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input int port, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        @(posedge clk); #1;
        if (port == 0) begin
            req0_val = 1'b1; req0_op = op; req0_in0 = a; req0_in1 = b;
        end else begin
            req1_val = 1'b1; req1_op = op; req1_in0 = a; req1_in1 = b;
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((port == 0) ? req0_rdy : req1_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        check("issue_accepted", ok, 1);
        @(posedge clk); #1;
        if (port == 0) req0_val = 1'b0;
        else           req1_val = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        req0_val = 1'b1; req0_op = 3'd1; req0_in0 = 32'd5; req0_in1 = 32'd7;
        req1_val = 1'b1; req1_op = 3'd2; req1_in0 = 32'd1; req1_in1 = 32'd31;

        // Reset state with both requesters already asking
        repeat (2) @(negedge clk);
        check("rst_req0_rdy", req0_rdy, 0);
        check("rst_req1_rdy", req1_rdy, 0);
        check("rst_resp0_val", resp0_val, 0);
        check("rst_resp1_val", resp1_val, 0);
        check("rst_cur_domain", cur_domain, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);

        // Contention from reset: grants alternate starting with requester 0
        grant_q.delete();
        fire_t.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (grant_q.size() >= 4) break;
        end
        req0_val = 1'b0;
        req1_val = 1'b0;
        check("contention_grant_count", grant_q.size(), 4);
        if (grant_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("contention_grant%0d", i), grant_q[i], i % 2);
                if (i > 0) check($sformatf("contention_spacing%0d", i), fire_t[i] - fire_t[i-1], SPACING);
            end
        end
        drain();

        // Single request: latency and carry drop
        issue(0, 3'd0, 32'hFFFF_FFFF, 32'h2);
        @(negedge clk);
        check("single_exec_no_val", resp0_val, 0);
        check("single_exec_busy", busy, 1);
        @(negedge clk);
        check("single_resp0_val", resp0_val, 1);
        check("single_resp0_data", resp0_data, 32'h1);
        check("single_resp1_val", resp1_val, 0);
        drain();

        // Backpressure on the secure port, with requester 0 waiting
        resp1_rdy = 1'b0;
        issue(1, 3'd6, 32'd3, 32'd3);
        req0_val = 1'b1; req0_op = 3'd0; req0_in0 = 32'd4; req0_in1 = 32'd5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp1_val) break;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_resp1_val", resp1_val, 1);
            check("bp_resp1_data", resp1_data, 32'h1);
            check("bp_req0_rdy", req0_rdy, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp1_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_rdy) break;
        end
        @(posedge clk); #1;
        req0_val = 1'b0;
        drain();

        // Isolation and domain tracking
        issue(1, 3'd4, 32'hA, 32'hA);
        @(negedge clk);
        check("iso_cur_domain_s", cur_domain, 1);
        drain();
        check("iso_cur_domain_idle", cur_domain, 0);
        issue(0, 3'd3, 32'h80, 32'd3);
        @(negedge clk);
        check("iso_cur_domain_ns", cur_domain, 0);
        drain();

        // Reset during EXEC discards the operation
        issue(0, 3'd0, 32'd1, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_resp0_val", resp0_val, 0);
        check("mid_rst_resp0_data", resp0_data, 0);
        check("mid_rst_cur_domain", cur_domain, 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_resp0", resp0_val, 0);
            check("post_rst_no_resp1", resp1_val, 0);
        end
        issue(0, 3'd0, 32'h10, 32'h20);
        drain();

        // A handful of random operations from both domains
        for (int i = 0; i < 6; i++) begin
            issue($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom);
            drain();
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
